led_scan_ctrl: RTL and testbench

Time-multiplexing controller for the 4-digit common-anode seven-segment display. It rotates the active-low anode select across the digits, inserts blanking gaps between them to prevent ghosting, and presents the matching BCD nibble on `code`. `code` feeds the BCD-to-segment decoder. The controller also double-buffers display data so that an update never tears mid-frame.

---
 rtl/led_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_led_scan_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// Multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Alternates blank and show phases per digit and double-buffers display data so a frame never tears.
module led_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dig_en,
  output logic [3:0]  an,
  output logic [3:0]  code,
  output logic        pending,
  output logic        frame_done
);

  localparam int MAXP = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t          r_state;
  logic [1:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_active;
  logic [15:0]     r_shadow;
  logic            r_pending;
  logic            r_wrap;
  logic            r_frame_done;
  logic [3:0]      r_an;
  logic [3:0]      r_code;

  logic            w_last;
  logic            w_wrap;
  logic [3:0]      w_an;
  logic [3:0]      w_code;

  // End-of-phase detection and the digit-3-to-digit-0 wrap
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      ST_BLANK: w_last = (r_cnt == BLANK_LAST);
      ST_SHOW:  w_last = (r_cnt == DIV_LAST);
      default:  w_last = 1'b0;
    endcase
    w_wrap = w_last && (r_state == ST_SHOW) && (r_idx == 2'd3);
  end

  // Anode/code decode of the current phase; dig_en is used live
  always_comb begin
    w_an   = 4'b1111;
    w_code = 4'b0000;
    if ((r_state == ST_SHOW) && dig_en[r_idx]) begin
      w_an   = ~(4'b0001 << r_idx);
      w_code = r_active[{r_idx, 2'b00} +: 4];
    end else begin
      w_an   = 4'b1111;
      w_code = 4'b0000;
    end
  end

  // Scan sequencer; outputs lag the phase state by one edge, so the
  // frame boundary is reported one edge after the internal wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      r_wrap       <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= 4'b1111;
      r_code       <= 4'b0000;
    end else begin
      r_an         <= w_an;
      r_code       <= w_code;
      r_wrap       <= w_wrap;
      r_frame_done <= r_wrap;
      if (w_last) begin
        r_cnt <= '0;
        if (r_state == ST_BLANK) begin
          r_state <= ST_SHOW;
        end else begin
          r_state <= ST_BLANK;
          r_idx   <= r_idx + 2'd1;
        end
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  // Double buffer: commit uses the pre-edge shadow, a same-edge load re-arms pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 16'h0000;
      r_shadow  <= 16'h0000;
      r_pending <= 1'b0;
    end else begin
      if (r_wrap && r_pending) begin
        r_active <= r_shadow;
      end
      if (load) begin
        r_shadow  <= data_in;
        r_pending <= 1'b1;
      end else if (r_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign an         = r_an;
  assign code       = r_code;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl: per-cycle expectations come from a cycle-number
// based reference model of the scan schedule and the double buffer.
module tb_led_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int P     = DIV + BLANK;
  localparam int FP    = 4 * P;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        load    = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dig_en  = 4'hF;
  logic [3:0]  an;
  logic [3:0]  code;
  logic        pending;
  logic        frame_done;

  led_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .dig_en     (dig_en),
    .an         (an),
    .code       (code),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] e;
    logic [3:0]  an;
    logic [3:0]  code;
    logic        pend;
    logic        fd;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  int          m_e    = 0;
  logic [15:0] m_act  = 16'h0000;
  logic [15:0] m_sh   = 16'h0000;
  logic        m_pend = 1'b0;
  logic [3:0]  cur_en = 4'hF;

  task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got {an,code,pend,fd}=%b expected %b", nm, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue what the following edge must produce
  task automatic tick(input logic l, input logic [15:0] d, input logic [3:0] en);
    int   u;
    int   dg;
    bit   bnd;
    bit   lit;
    exp_t x;
    @(negedge clk);
    load    = l;
    data_in = d;
    dig_en  = en;
    m_e++;
    u   = m_e - 1;
    dg  = (u / P) % 4;
    bnd = (u > 0) && (u % FP == 0);
    lit = ((u % P) >= BLANK) && en[dg];
    if (bnd && m_pend) m_act = m_sh;
    if (l) begin
      m_sh   = d;
      m_pend = 1'b1;
    end else if (bnd) begin
      m_pend = 1'b0;
    end
    x.e    = m_e;
    x.an   = lit ? ~(4'b0001 << dg) : 4'b1111;
    x.code = lit ? m_act[dg*4 +: 4] : 4'b0000;
    x.pend = m_pend;
    x.fd   = bnd;
    sb_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, cur_en);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    #1;
    chk("async reset", {an, code, pending, frame_done}, 10'b1111_0000_0_0);
    @(posedge clk);
    #3;
    chk("reset hold", {an, code, pending, frame_done}, 10'b1111_0000_0_0);
    rst_n  = 1'b1;
    m_e    = 0;
    m_act  = 16'h0000;
    m_sh   = 16'h0000;
    m_pend = 1'b0;
  endtask

  // Monitor: pop one expectation per post-reset edge and compare
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        x = sb_q.pop_front();
        n_vec++;
        if ({an, code, pending, frame_done} !== {x.an, x.code, x.pend, x.fd}) begin
          n_err++;
          $display("FAIL cycle %0d: an=%b code=%h pending=%b frame_done=%b, expected an=%b code=%h pending=%b frame_done=%b",
                   x.e, an, code, pending, frame_done, x.an, x.code, x.pend, x.fd);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1);
  end

  initial begin : stimulus
    do_reset();
    idle(30);
    tick(1'b1, 16'h4321, cur_en);
    idle(2 * FP);
    tick(1'b1, 16'h1111, cur_en);
    idle(3);
    tick(1'b1, 16'h9876, cur_en);
    idle(2 * FP);
    // Arm pending with 2222, then load 5555 exactly on the boundary edge
    tick(1'b1, 16'h2222, cur_en);
    while (m_e % FP != 0) idle(1);
    tick(1'b1, 16'h5555, cur_en);
    idle(2 * FP + 4);
    cur_en = 4'b0101;
    idle(FP + 6);
    cur_en = 4'hF;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) cur_en = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 15) == 0, 16'($urandom), cur_en);
    end
    cur_en = 4'hF;
    tick(1'b1, 16'h8765, cur_en);
    idle(FP);
    // Reset in the middle of digit 2's show phase
    while (((m_e - 1) % FP) != 15) idle(1);
    do_reset();
    idle(FP + 4);
    @(posedge clk);
    #3;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
